// File: rtl/tcdm_bank_responder.sv
// tcdm_bank_responder: TCDM bank target executing loads, stores, AMOs and LR/SC against one SRAM bank.
package tcdm_bank_responder_pkg;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned MetaIdWidth = 4;
  localparam int unsigned CoreIdWidth = 2;
  localparam int unsigned IniAddrWidth = 3;
  localparam int unsigned AddrWidth = 16;
  localparam int unsigned TCDMAddrMemWidth = 8;
  typedef logic [DataWidth-1:0] data_t;
  typedef logic [DataWidth/8-1:0] strb_t;
  typedef logic [TCDMAddrMemWidth-1:0] bank_addr_t;
  typedef logic [3:0] amo_t;
  typedef struct packed {
    logic [MetaIdWidth-1:0] meta_id;
    logic [CoreIdWidth-1:0] core_id;
    amo_t                   amo;
    data_t                  data;
  } tcdm_payload_t;
  typedef struct packed {
    tcdm_payload_t           wdata;
    logic                    wen;
    strb_t                   be;
    logic [AddrWidth-1:0]    tgt_addr;
    logic [IniAddrWidth-1:0] ini_addr;
  } tcdm_slave_req_t;
  typedef struct packed {
    tcdm_payload_t           rdata;
    logic [IniAddrWidth-1:0] ini_addr;
  } tcdm_slave_resp_t;
endpackage

module tcdm_bank_responder import tcdm_bank_responder_pkg::*; #(
  parameter int unsigned RespDepth    = 2,
  parameter bit          LrScEn       = 1'b1,
  parameter int unsigned BankSelWidth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  tcdm_slave_req_t  req_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output tcdm_slave_resp_t resp_o,
  output logic             bank_req_o,
  output logic             bank_we_o,
  output bank_addr_t       bank_addr_o,
  output data_t            bank_wdata_o,
  output strb_t            bank_be_o,
  input  data_t            bank_rdata_i
);
  localparam int unsigned PtrW = RespDepth > 1 ? $clog2(RespDepth) : 1;
  localparam int unsigned CntW = $clog2(RespDepth + 1);
  typedef enum logic {IDLE, AMO_WR} state_e;
  state_e state_q;
  logic pend_q, pend_rd_q;
  tcdm_slave_resp_t pend_resp_q, acc_resp, push_data;
  data_t opnd_q, amo_res;
  bank_addr_t amo_row_q, row;
  logic resv_valid_q;
  logic [IniAddrWidth-1:0] resv_ini_q;
  logic [CoreIdWidth-1:0] resv_core_q;
  bank_addr_t resv_row_q;
  tcdm_slave_resp_t mem_q [RespDepth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW:0] inflight;
  amo_t amo;
  logic is_amo, is_lr, is_sc, is_plain, sc_ok, accept, acc_wr, needs_resp, amo_wr, push, pop;
  logic unused_addr;
  assign unused_addr = ^req_i.tgt_addr;
  assign amo = req_i.wdata.amo;
  assign row = req_i.tgt_addr[BankSelWidth +: TCDMAddrMemWidth];
  assign is_amo = amo >= 4'h1 && amo <= 4'h9;
  assign is_lr = LrScEn && amo == 4'hA;
  assign is_sc = amo == 4'hB;
  assign is_plain = !is_amo && !is_lr && !is_sc;
  // Without LR/SC support every SC succeeds, i.e. acts as a store answering 0
  assign sc_ok = !LrScEn || (resv_valid_q && resv_ini_q == req_i.ini_addr &&
                             resv_core_q == req_i.wdata.core_id && resv_row_q == row);
  assign inflight = {1'b0, cnt_q} + (CntW+1)'(pend_q);
  assign req_ready_o = rst_ni && state_q == IDLE && inflight < (CntW+1)'(RespDepth);
  assign accept = req_valid_i && req_ready_o;
  assign acc_wr = accept && ((is_plain && req_i.wen) || (is_sc && sc_ok));
  assign needs_resp = !(is_plain && req_i.wen);
  assign amo_wr = state_q == AMO_WR;
  assign bank_req_o = accept || amo_wr;
  assign bank_we_o = acc_wr || amo_wr;
  assign bank_addr_o = amo_wr ? amo_row_q : accept ? row : '0;
  assign bank_wdata_o = amo_wr ? amo_res : accept ? req_i.wdata.data : '0;
  assign bank_be_o = amo_wr ? '1 : accept ? req_i.be : '0;
  always_comb begin
    case (pend_resp_q.rdata.amo)
      4'h2:    amo_res = bank_rdata_i + opnd_q;
      4'h3:    amo_res = bank_rdata_i & opnd_q;
      4'h4:    amo_res = bank_rdata_i | opnd_q;
      4'h5:    amo_res = bank_rdata_i ^ opnd_q;
      4'h6:    amo_res = $signed(bank_rdata_i) > $signed(opnd_q) ? bank_rdata_i : opnd_q;
      4'h7:    amo_res = bank_rdata_i > opnd_q ? bank_rdata_i : opnd_q;
      4'h8:    amo_res = $signed(bank_rdata_i) < $signed(opnd_q) ? bank_rdata_i : opnd_q;
      4'h9:    amo_res = bank_rdata_i < opnd_q ? bank_rdata_i : opnd_q;
      default: amo_res = opnd_q;
    endcase
  end
  always_comb begin
    acc_resp = '{rdata: req_i.wdata, ini_addr: req_i.ini_addr};
    acc_resp.rdata.data = data_t'(!sc_ok);
    push_data = pend_resp_q;
    push_data.rdata.data = pend_rd_q ? bank_rdata_i : pend_resp_q.rdata.data;
  end
  // Fall-through FIFO: an empty FIFO presents the entry being pushed directly
  assign push = pend_q;
  assign resp_valid_o = cnt_q != '0 || push;
  assign resp_o = cnt_q == '0 ? push_data : mem_q[rptr_q];
  assign pop = resp_valid_o && resp_ready_i;
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= push_data;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      pend_q       <= 1'b0;
      pend_rd_q    <= 1'b0;
      pend_resp_q  <= '0;
      opnd_q       <= '0;
      amo_row_q    <= '0;
      resv_valid_q <= 1'b0;
      resv_ini_q   <= '0;
      resv_core_q  <= '0;
      resv_row_q   <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q <= accept && is_amo ? AMO_WR : IDLE;
      pend_q  <= accept && needs_resp;
      if (accept) begin
        pend_rd_q   <= !is_sc;
        pend_resp_q <= acc_resp;
        opnd_q      <= req_i.wdata.data;
        amo_row_q   <= row;
      end
      if (accept && is_lr) begin
        resv_valid_q <= 1'b1;
        resv_ini_q   <= req_i.ini_addr;
        resv_core_q  <= req_i.wdata.core_id;
        resv_row_q   <= row;
      end else if ((accept && is_sc) || (bank_we_o && bank_addr_o == resv_row_q)) begin
        resv_valid_q <= 1'b0;
      end
      if (push) wptr_q <= wptr_q == PtrW'(RespDepth - 1) ? '0 : wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q == PtrW'(RespDepth - 1) ? '0 : rptr_q + 1'b1;
      cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
    end
  end
  a_resp_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    resp_valid_o && !resp_ready_i |=> $stable(resp_o));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> cnt_q < CntW'(RespDepth));
  a_rdata_after_read: assert property (@(posedge clk_i) disable iff (!rst_ni)
    pend_q && pend_rd_q |-> $past(bank_req_o && !bank_we_o));
endmodule
